// File: rtl/signal_conflict_monitor.sv
// Safety monitor between the four-way light controller and the physical lamps.
// Registers the lamp drive, checks every cycle for illegal light combinations and
// sequences, and on a violation latches a fault and flashes all reds until cleared.
// Optional feature: define FAULT_COUNT_EN to enable the saturating fault counter.
module signal_conflict_monitor #(
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter int unsigned MIN_YELLOW     = 40000000,
    parameter int unsigned RECOVER_CYCLES = 50000000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  north,
    input  logic [1:0]  east,
    input  logic [1:0]  south,
    input  logic [1:0]  west,
    input  logic        clr_fault,
    output logic [11:0] lamp,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [7:0]  fault_count
);

    localparam int unsigned YW = $clog2(MIN_YELLOW + 1);
    localparam int unsigned BW = $clog2(BLINK_DIV);
    localparam int unsigned PW = $clog2(2 * BLINK_DIV);
    localparam int unsigned RW = $clog2(RECOVER_CYCLES + 1);

    localparam logic [YW-1:0] YellowMin  = YW'(MIN_YELLOW);
    localparam logic [BW-1:0] BlinkLast  = BW'(BLINK_DIV - 1);
    localparam logic [PW-1:0] PeriodLast = PW'(2 * BLINK_DIV - 1);
    localparam logic [RW-1:0] RecLast    = RW'(RECOVER_CYCLES - 1);

    localparam logic [1:0]  CodeRed    = 2'b00;
    localparam logic [1:0]  CodeYellow = 2'b01;
    localparam logic [1:0]  CodeGreen  = 2'b10;
    localparam logic [1:0]  CodeBad    = 2'b11;
    localparam logic [11:0] AllRed     = 12'b100_100_100_100;

    typedef enum logic [1:0] {
        StInit,
        StMonitor,
        StFaultFlash,
        StRecover
    } state_e;

    state_e               state_q, state_d;
    logic [11:0]          lamp_q, lamp_d;
    logic                 fault_q, fault_d;
    logic [2:0]           code_q, code_d;
    logic [3:0][1:0]      prev_q, prev_d;
    logic [3:0][YW-1:0]   ycnt_q, ycnt_d, ycnt_next;
    logic [BW-1:0]        blink_q, blink_d;
    logic [PW-1:0]        period_q, period_d;
    logic [RW-1:0]        rec_q, rec_d;

    // Index 3 is north, 0 is west, matching the lamp bit order.
    logic [3:0][1:0] codes;
    logic [11:0]     lamp_decoded;
    logic [2:0]      viol_code;

    assign codes = {north, east, south, west};

    function automatic logic [2:0] decode_rgb(input logic [1:0] c);
        logic [2:0] r;
        unique case (c)
            CodeRed:    r = 3'b100;
            CodeYellow: r = 3'b010;
            CodeGreen:  r = 3'b001;
            default:    r = 3'b000;
        endcase
        return r;
    endfunction

    // Violation detection and per-direction yellow-time tracking.
    always_comb begin
        logic       v_bad, v_multi_green, v_skip_yellow, v_short_yellow;
        logic [2:0] n_green;
        v_bad          = 1'b0;
        v_multi_green  = 1'b0;
        v_skip_yellow  = 1'b0;
        v_short_yellow = 1'b0;
        n_green        = 3'd0;
        lamp_decoded   = '0;
        ycnt_next      = '0;
        for (int i = 0; i < 4; i++) begin
            if (codes[i] == CodeBad) v_bad = 1'b1;
            if (codes[i] == CodeGreen) n_green = n_green + 3'd1;
            if (prev_q[i] == CodeGreen && codes[i] == CodeRed) v_skip_yellow = 1'b1;
            if (prev_q[i] == CodeYellow && codes[i] != CodeYellow && ycnt_q[i] < YellowMin) begin
                v_short_yellow = 1'b1;
            end
            lamp_decoded[3*i +: 3] = decode_rgb(codes[i]);
            if (codes[i] == CodeYellow) begin
                ycnt_next[i] = (ycnt_q[i] == YellowMin) ? ycnt_q[i] : ycnt_q[i] + YW'(1);
            end
        end
        v_multi_green = (n_green >= 3'd2);
        // Lowest code wins when several checks fire together.
        if (v_bad)               viol_code = 3'd1;
        else if (v_multi_green)  viol_code = 3'd2;
        else if (v_skip_yellow)  viol_code = 3'd3;
        else if (v_short_yellow) viol_code = 3'd4;
        else                     viol_code = 3'd0;
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d  = state_q;
        lamp_d   = lamp_q;
        fault_d  = fault_q;
        code_d   = code_q;
        prev_d   = prev_q;
        ycnt_d   = ycnt_q;
        blink_d  = blink_q;
        period_d = period_q;
        rec_d    = rec_q;
        unique case (state_q)
            StInit: begin
                prev_d  = codes;
                ycnt_d  = '0;
                lamp_d  = AllRed;
                fault_d = 1'b0;
                state_d = StMonitor;
            end
            StMonitor: begin
                if (viol_code != 3'd0) begin
                    // Flash starts with reds on, so the bad pattern never reaches a lamp.
                    state_d  = StFaultFlash;
                    fault_d  = 1'b1;
                    code_d   = viol_code;
                    lamp_d   = AllRed;
                    blink_d  = '0;
                    period_d = '0;
                end else begin
                    lamp_d = lamp_decoded;
                    prev_d = codes;
                    ycnt_d = ycnt_next;
                end
            end
            StFaultFlash: begin
                if (period_q != PeriodLast) period_d = period_q + PW'(1);
                if (blink_q == BlinkLast) begin
                    blink_d = '0;
                    lamp_d  = lamp_q ^ AllRed;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
                // A held clear waits for one full on/off period before taking effect.
                if (clr_fault && period_q == PeriodLast) begin
                    state_d = StRecover;
                    fault_d = 1'b0;
                    lamp_d  = AllRed;
                    rec_d   = '0;
                end
            end
            StRecover: begin
                lamp_d = AllRed;
                if (rec_q == RecLast) begin
                    state_d = StInit;
                    code_d  = 3'd0;
                    rec_d   = '0;
                end else begin
                    rec_d = rec_q + RW'(1);
                end
            end
            default: state_d = StInit;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StInit;
            lamp_q   <= AllRed;
            fault_q  <= 1'b0;
            code_q   <= 3'd0;
            prev_q   <= '0;
            ycnt_q   <= '0;
            blink_q  <= '0;
            period_q <= '0;
            rec_q    <= '0;
        end else begin
            state_q  <= state_d;
            lamp_q   <= lamp_d;
            fault_q  <= fault_d;
            code_q   <= code_d;
            prev_q   <= prev_d;
            ycnt_q   <= ycnt_d;
            blink_q  <= blink_d;
            period_q <= period_d;
            rec_q    <= rec_d;
        end
    end

    assign lamp       = lamp_q;
    assign fault      = fault_q;
    assign fault_code = code_q;

`ifdef FAULT_COUNT_EN
    logic [7:0] fcnt_q;

    // Count each entry into fault flash, saturating at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt_q <= 8'd0;
        end else if (state_q == StMonitor && viol_code != 3'd0 && fcnt_q != 8'hFF) begin
            fcnt_q <= fcnt_q + 8'd1;
        end
    end

    assign fault_count = fcnt_q;
`else
    assign fault_count = 8'd0;
`endif

endmodule

// File: tb/tb_signal_conflict_monitor.sv
// Directed, table-driven bench for signal_conflict_monitor with small timing parameters.
module tb_signal_conflict_monitor;

    localparam logic [1:0]  R   = 2'b00;
    localparam logic [1:0]  Y   = 2'b01;
    localparam logic [1:0]  G   = 2'b10;
    localparam logic [1:0]  X   = 2'b11;
    localparam logic [11:0] AR  = 12'b100_100_100_100;
    localparam logic [11:0] OFF = 12'b000_000_000_000;

    logic        clk;
    logic        rst_n;
    logic [1:0]  north, east, south, west;
    logic        clr_fault;
    logic [11:0] lamp;
    logic        fault;
    logic [2:0]  fault_code;
    logic [7:0]  fault_count;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [1:0]  n, e, s, w;
        logic        clr;
        logic [11:0] lamp;
        logic        fault;
        logic [2:0]  code;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    signal_conflict_monitor #(
        .BLINK_DIV      (4),
        .MIN_YELLOW     (3),
        .RECOVER_CYCLES (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .north       (north),
        .east        (east),
        .south       (south),
        .west        (west),
        .clr_fault   (clr_fault),
        .lamp        (lamp),
        .fault       (fault),
        .fault_code  (fault_code),
        .fault_count (fault_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] dec(input logic [1:0] c);
        case (c)
            R:       return 3'b100;
            Y:       return 3'b010;
            G:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [11:0] lz(input logic [1:0] n, e, s, w);
        return {dec(n), dec(e), dec(s), dec(w)};
    endfunction

    function automatic logic [7:0] exp_cnt(input logic [7:0] c);
`ifdef FAULT_COUNT_EN
        return c;
`else
        return 8'd0 & c;
`endif
    endfunction

    task automatic row(input logic [1:0] n, e, s, w, input logic clr, input logic [11:0] lp,
                       input logic flt, input logic [2:0] code, input logic [7:0] cnt);
        vec_t v;
        v.n = n; v.e = e; v.s = s; v.w = w; v.clr = clr;
        v.lamp = lp; v.fault = flt; v.code = code; v.cnt = cnt;
        tbl.push_back(v);
    endtask

    // Rows following a fault edge: flash, optional clear from flash cycle clr_from,
    // exit after one full period, five cycles of recover, INIT, then monitoring.
    task automatic fault_tail(input logic [2:0] code, input logic [7:0] cnt, input int clr_from);
        logic c;
        for (int j = 1; j < 40; j++) begin
            c = (j >= clr_from);
            if (j >= 8 && c) begin
                row(R, R, R, R, 1'b1, AR, 1'b0, code, cnt);
                break;
            end
            row(R, R, R, R, c, ((j / 4) % 2 == 0) ? AR : OFF, 1'b1, code, cnt);
        end
        repeat (4) row(R, R, R, R, 1'b0, AR, 1'b0, code, cnt);
        row(R, R, R, R, 1'b0, AR, 1'b0, 3'd0, cnt);
        row(R, R, R, R, 1'b0, AR, 1'b0, 3'd0, cnt);
        row(R, R, R, R, 1'b0, AR, 1'b0, 3'd0, cnt);
    endtask

    task automatic chk(input string nm, input int idx, input logic [11:0] act,
                       input logic [11:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s step %0d: got %h, required %h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input int idx, input logic [11:0] lp, input logic flt,
                             input logic [2:0] code, input logic [7:0] cnt);
        chk("lamp", idx, lamp, lp);
        chk("fault", idx, {11'd0, fault}, {11'd0, flt});
        chk("fault_code", idx, {9'd0, fault_code}, {9'd0, code});
        chk("fault_count", idx, {4'd0, fault_count}, {4'd0, exp_cnt(cnt)});
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;

        // INIT edge, then first monitoring edge.
        row(R, R, R, R, 1'b0, AR, 1'b0, 3'd0, 8'd0);
        row(R, R, R, R, 1'b0, AR, 1'b0, 3'd0, 8'd0);
        // Legal cycle: N green 10, N yellow 3 (exact minimum), then E green.
        repeat (10) row(G, R, R, R, 1'b0, lz(G, R, R, R), 1'b0, 3'd0, 8'd0);
        repeat (3)  row(Y, R, R, R, 1'b0, lz(Y, R, R, R), 1'b0, 3'd0, 8'd0);
        repeat (2)  row(R, G, R, R, 1'b0, lz(R, G, R, R), 1'b0, 3'd0, 8'd0);
        // E yellow longer than minimum (counter saturates), then N green.
        repeat (5)  row(R, Y, R, R, 1'b0, lz(R, Y, R, R), 1'b0, 3'd0, 8'd0);
        row(G, R, R, R, 1'b0, lz(G, R, R, R), 1'b0, 3'd0, 8'd0);
        // Two greens: code 2, no clear until after the first full period.
        row(G, G, R, R, 1'b0, AR, 1'b1, 3'd2, 8'd1);
        fault_tail(3'd2, 8'd1, 9);
        // Green straight to red: code 3, clear held from the start.
        row(G, R, R, R, 1'b0, lz(G, R, R, R), 1'b0, 3'd0, 8'd1);
        row(R, R, R, R, 1'b0, AR, 1'b1, 3'd3, 8'd2);
        fault_tail(3'd3, 8'd2, 1);
        // Green straight to red together with an illegal code: code 1 wins.
        row(G, R, R, R, 1'b0, lz(G, R, R, R), 1'b0, 3'd0, 8'd2);
        row(R, X, R, R, 1'b0, AR, 1'b1, 3'd1, 8'd3);
        fault_tail(3'd1, 8'd3, 5);
        // Yellow for only 2 cycles: code 4, clear from flash cycle 3.
        repeat (2) row(Y, R, R, R, 1'b0, lz(Y, R, R, R), 1'b0, 3'd0, 8'd3);
        row(R, R, R, R, 1'b0, AR, 1'b1, 3'd4, 8'd4);
        fault_tail(3'd4, 8'd4, 3);
        row(R, R, G, R, 1'b0, lz(R, R, G, R), 1'b0, 3'd0, 8'd4);

        rst_n = 1'b0;
        north = R; east = R; south = R; west = R;
        clr_fault = 1'b0;
        step();
        step();
        check_all(-1, AR, 1'b0, 3'd0, 8'd0);
        #3 rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            north = tbl[i].n; east = tbl[i].e; south = tbl[i].s; west = tbl[i].w;
            clr_fault = tbl[i].clr;
            step();
            check_all(i, tbl[i].lamp, tbl[i].fault, tbl[i].code, tbl[i].cnt);
        end

        // Asynchronous reset in the middle of fault flash.
        north = R; east = R; south = R; west = X;
        step();
        check_all(1000, AR, 1'b1, 3'd1, 8'd5);
        west = R;
        step();
        step();
        #2 rst_n = 1'b0;
        #1 check_all(1001, AR, 1'b0, 3'd0, 8'd0);
        #2 rst_n = 1'b1;
        step();
        check_all(1002, AR, 1'b0, 3'd0, 8'd0);
        step();
        check_all(1003, AR, 1'b0, 3'd0, 8'd0);
        north = G;
        step();
        check_all(1004, lz(G, R, R, R), 1'b0, 3'd0, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
